mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory bus between the processor core and a secondary bus master (DMA / program loader).
- Latches each granted request, holds it on the memory bus until the memory acknowledges or a timeout fires, then returns data/ack to the owner.
- Generates the processor's stall/ready input, so the core's step counter advances only when its memory access has completed.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU port, DMA port, memory port and status.
// Requests are level-held until completion, and memory strobes are held until iMemAck.
// Each completion lasts a single cycle: oCpuRdy / oDmaAck (plus oBusErr on a timeout abort).
interface mem_port_arbiter_if;
  logic [31:0] iCpuAddr;
  logic [31:0] iCpuWData;
  logic        iCpuRead;
  logic        iCpuWrite;
  logic [31:0] oCpuRData;
  logic        oCpuRdy;
  logic [31:0] iDmaAddr;
  logic [31:0] iDmaWData;
  logic        iDmaRead;
  logic        iDmaWrite;
  logic [31:0] oDmaRData;
  logic        oDmaAck;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] iMemRData;
  logic        iMemAck;
  logic [1:0]  oGrant;
  logic        oBusErr;

  modport slave (
    input  iCpuAddr, iCpuWData, iCpuRead, iCpuWrite,
    input  iDmaAddr, iDmaWData, iDmaRead, iDmaWrite,
    input  iMemRData, iMemAck,
    output oCpuRData, oCpuRdy, oDmaRData, oDmaAck,
    output oMemAddr, oMemWData, oMemRead, oMemWrite,
    output oGrant, oBusErr
  );

  modport master (
    output iCpuAddr, iCpuWData, iCpuRead, iCpuWrite,
    output iDmaAddr, iDmaWData, iDmaRead, iDmaWrite,
    output iMemRData, iMemAck,
    input  oCpuRData, oCpuRdy, oDmaRData, oDmaAck,
    input  oMemAddr, oMemWData, oMemRead, oMemWrite,
    input  oGrant, oBusErr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between CPU and DMA,
// with per-transfer timeout abort and the CPU ready/stall generation.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                iClk,
  input  logic                iRst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DMA_XFER = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_dma_q, last_dma_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        cpu_req, dma_req;
  logic        grant_cpu, grant_dma;
  logic        in_xfer, timeout, done;
  logic        cpu_done, dma_done;
  logic [31:0] rdata_sel;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;

    cpu_req   = bus.iCpuRead | bus.iCpuWrite;
    dma_req   = bus.iDmaRead | bus.iDmaWrite;
    // On a tie the CPU wins only if the DMA owned the bus last.
    grant_cpu = cpu_req & (~dma_req | last_dma_q);
    grant_dma = dma_req & ~grant_cpu;

    in_xfer = (state_q != IDLE);
    timeout = in_xfer & ~bus.iMemAck & (cnt_q == CNT_LAST);
    // A reset cycle abandons the transfer silently: no completion, no error.
    done    = in_xfer & (bus.iMemAck | timeout) & ~iRst;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d    = CPU_XFER;
          addr_d     = bus.iCpuAddr;
          wdata_d    = bus.iCpuWData;
          wr_d       = bus.iCpuWrite;
          rd_d       = bus.iCpuRead & ~bus.iCpuWrite;
          last_dma_d = 1'b0;
          cnt_d      = '0;
        end else if (grant_dma) begin
          state_d    = DMA_XFER;
          addr_d     = bus.iDmaAddr;
          wdata_d    = bus.iDmaWData;
          wr_d       = bus.iDmaWrite;
          rd_d       = bus.iDmaRead & ~bus.iDmaWrite;
          last_dma_d = 1'b1;
          cnt_d      = '0;
        end
      end
      CPU_XFER, DMA_XFER: begin
        if (!bus.iMemAck) cnt_d = cnt_q + 16'd1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_done  = done & (state_q == CPU_XFER);
  assign dma_done  = done & (state_q == DMA_XFER);
  assign rdata_sel = bus.iMemAck ? bus.iMemRData : ERR_DATA;

  // The memory side is driven only from the holding registers while a transfer is live.
  assign bus.oMemAddr  = in_xfer ? addr_q  : 32'h0;
  assign bus.oMemWData = in_xfer ? wdata_q : 32'h0;
  assign bus.oMemRead  = in_xfer & rd_q;
  assign bus.oMemWrite = in_xfer & wr_q;

  assign bus.oCpuRdy   = ~cpu_req | cpu_done;
  assign bus.oCpuRData = cpu_done ? rdata_sel : 32'h0;
  assign bus.oDmaAck   = dma_done;
  assign bus.oDmaRData = dma_done ? rdata_sel : 32'h0;
  assign bus.oGrant    = {state_q == DMA_XFER, state_q == CPU_XFER};
  assign bus.oBusErr   = done & ~bus.iMemAck;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [1:0] dbg_state;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          forced_lat = -1;
  int          cur_lat    = 0;
  int          mem_age    = 0;
  logic        fixed_en   = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 8) ? (r % 4) : 99;
  endfunction

  always @(posedge iClk) begin
    #1;
    if (bus.oMemRead === 1'b1 || bus.oMemWrite === 1'b1) begin
      if (mem_age == 0) cur_lat = (forced_lat >= 0) ? forced_lat : pick_lat();
      bus.iMemAck = (mem_age == cur_lat);
      mem_age++;
    end else begin
      mem_age     = 0;
      bus.iMemAck = 1'b0;
    end
    bus.iMemRData = fixed_en ? fixed_data : $urandom();
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Owner: 0 none, 1 CPU, 2 DMA. age = cycles the current transfer has been on the bus.
  int          m_owner = 0;
  int          m_last  = 2;
  int          m_age   = 0;
  logic [31:0] m_addr, m_wdata;
  logic        m_rd, m_wr;
  bit          m_valid = 1'b0;

  always @(negedge iClk) begin
    logic        cpu_req, dma_req, ack, done;
    logic [31:0] rsel;
    cpu_req = bus.iCpuRead | bus.iCpuWrite;
    dma_req = bus.iDmaRead | bus.iDmaWrite;
    if (iRst) begin
      if (m_valid) begin
        chk("rst_dma_ack", 32'(bus.oDmaAck), 32'h0);
        chk("rst_bus_err", 32'(bus.oBusErr), 32'h0);
      end
      m_valid = 1'b1;
      m_owner = 0; m_last = 2; m_age = 0;
      m_addr = 32'h0; m_wdata = 32'h0; m_rd = 1'b0; m_wr = 1'b0;
    end else if (m_valid) begin
      ack  = bus.iMemAck;
      done = (m_owner != 0) && (ack || m_age == TO - 1);
      rsel = ack ? bus.iMemRData : ERR;
      chk("m_grant",     32'(bus.oGrant),    32'(m_owner));
      chk("m_mem_addr",  bus.oMemAddr,       (m_owner != 0) ? m_addr  : 32'h0);
      chk("m_mem_wdata", bus.oMemWData,      (m_owner != 0) ? m_wdata : 32'h0);
      chk("m_mem_read",  32'(bus.oMemRead),  32'((m_owner != 0) && m_rd));
      chk("m_mem_write", 32'(bus.oMemWrite), 32'((m_owner != 0) && m_wr));
      chk("m_cpu_rdy",   32'(bus.oCpuRdy),   32'(!cpu_req || (done && m_owner == 1)));
      chk("m_cpu_rdata", bus.oCpuRData,      (done && m_owner == 1) ? rsel : 32'h0);
      chk("m_dma_ack",   32'(bus.oDmaAck),   32'(done && m_owner == 2));
      chk("m_dma_rdata", bus.oDmaRData,      (done && m_owner == 2) ? rsel : 32'h0);
      chk("m_bus_err",   32'(bus.oBusErr),   32'(done && !ack));
      if (m_owner == 0) begin
        if (cpu_req && dma_req) m_owner = 3 - m_last;
        else if (cpu_req)       m_owner = 1;
        else if (dma_req)       m_owner = 2;
        if (m_owner == 1) begin
          m_addr = bus.iCpuAddr; m_wdata = bus.iCpuWData;
          m_wr = bus.iCpuWrite;  m_rd = bus.iCpuRead & ~bus.iCpuWrite;
        end else if (m_owner == 2) begin
          m_addr = bus.iDmaAddr; m_wdata = bus.iDmaWData;
          m_wr = bus.iDmaWrite;  m_rd = bus.iDmaRead & ~bus.iDmaWrite;
        end
        if (m_owner != 0) begin m_last = m_owner; m_age = 0; end
      end else if (done) begin
        m_owner = 0;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- scenario statistics ----------------
  logic [1:0]  exp_q[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  prev_grant;
  int          rd_cycles, wr_cycles, cpu_done_cnt, dma_ack_cnt, err_cnt, err_with_ack, rdy_req_cnt;
  logic [31:0] cpu_rdata, dma_rdata, dma_wdata;

  task automatic clear_stats();
    grant_log.delete();
    prev_grant = 2'b00;
    rd_cycles = 0; wr_cycles = 0; cpu_done_cnt = 0; dma_ack_cnt = 0;
    err_cnt = 0; err_with_ack = 0; rdy_req_cnt = 0;
    cpu_rdata = 32'h0; dma_rdata = 32'h0; dma_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.iCpuRead = 1'b0; bus.iCpuWrite = 1'b0;
    bus.iDmaRead = 1'b0; bus.iDmaWrite = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    iRst = 1'b1;
    step();
    step();
    iRst = 1'b0;
  endtask

  // Runs up to n cycles collecting statistics; optionally drops a request the cycle after it completes.
  task automatic run(input int n, input bit drop, input bit stop_when_quiet);
    bit cpu_fin, dma_fin;
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      if (bus.oGrant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(bus.oGrant);
      prev_grant = bus.oGrant;
      if (bus.oMemRead)  rd_cycles++;
      if (bus.oMemWrite) wr_cycles++;
      if ((bus.iCpuRead | bus.iCpuWrite) && bus.oCpuRdy) rdy_req_cnt++;
      if (bus.oGrant == 2'b10) dma_wdata = bus.oMemWData;
      cpu_fin = (bus.oGrant == 2'b01) && bus.oCpuRdy;
      dma_fin = bus.oDmaAck;
      if (cpu_fin) begin cpu_done_cnt++; cpu_rdata = bus.oCpuRData; end
      if (dma_fin) begin dma_ack_cnt++; dma_rdata = bus.oDmaRData; end
      if (bus.oBusErr) begin
        err_cnt++;
        if (cpu_fin || dma_fin) err_with_ack++;
      end
      step();
      if (drop && cpu_fin) begin bus.iCpuRead = 1'b0; bus.iCpuWrite = 1'b0; end
      if (drop && dma_fin) begin bus.iDmaRead = 1'b0; bus.iDmaWrite = 1'b0; end
      if (stop_when_quiet && !(bus.iCpuRead | bus.iCpuWrite | bus.iDmaRead | bus.iDmaWrite)) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rb;
    iRst = 1'b1;
    bus.iCpuAddr = 32'h0; bus.iCpuWData = 32'h0;
    bus.iDmaAddr = 32'h0; bus.iDmaWData = 32'h0;
    clear_reqs();
    step();
    step();
    iRst = 1'b0;

    // Reset state
    @(negedge iClk);
    chk("reset_grant",  32'(bus.oGrant),    32'h0);
    chk("reset_rd",     32'(bus.oMemRead),  32'h0);
    chk("reset_wr",     32'(bus.oMemWrite), 32'h0);
    chk("reset_addr",   bus.oMemAddr,       32'h0);
    chk("reset_dmaack", 32'(bus.oDmaAck),   32'h0);
    chk("reset_err",    32'(bus.oBusErr),   32'h0);
    chk("reset_rdy",    32'(bus.oCpuRdy),   32'h1);
    step();

    // CPU read alone, ack in the third strobe cycle
    clear_stats();
    fixed_en = 1'b1; fixed_data = 32'h12345678; forced_lat = 2;
    bus.iCpuAddr = 32'h100; bus.iCpuRead = 1'b1;
    run(20, 1'b1, 1'b1);
    chk("s1_read_cycles", 32'(rd_cycles),    32'd3);
    chk("s1_rdy_count",   32'(rdy_req_cnt),  32'd1);
    chk("s1_rdata",       cpu_rdata,         32'h12345678);
    chk("s1_grant_first", 32'(grant_log.size() > 0 ? grant_log[0] : 2'b00), 32'h1);
    @(negedge iClk);
    chk("s1_grant_after", 32'(bus.oGrant), 32'h0);
    step();

    // Simultaneous CPU read and DMA write after reset: CPU first
    do_reset();
    clear_stats();
    forced_lat = 1;
    bus.iCpuAddr = 32'h0;  bus.iCpuRead = 1'b1;
    bus.iDmaAddr = 32'h40; bus.iDmaWData = 32'hA5A5A5A5; bus.iDmaWrite = 1'b1;
    run(30, 1'b1, 1'b1);
    chk("s2_grant_count", 32'(grant_log.size()), 32'd2);
    chk("s2_first",  32'(grant_log.size() > 0 ? grant_log[0] : 2'b00), 32'h1);
    chk("s2_second", 32'(grant_log.size() > 1 ? grant_log[1] : 2'b00), 32'h2);
    chk("s2_dma_wdata", dma_wdata, 32'hA5A5A5A5);
    chk("s2_dma_acks",  32'(dma_ack_cnt), 32'd1);
    chk("s2_wr_cycles", 32'(wr_cycles),   32'd2);

    // Continuous contention with zero-latency memory: strict alternation
    do_reset();
    clear_stats();
    forced_lat = 0;
    bus.iCpuRead = 1'b1; bus.iDmaRead = 1'b1;
    run(12, 1'b0, 1'b0);
    clear_reqs();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    chk("s3_grant_count", 32'(grant_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      chk("s3_grant_order", 32'(i < grant_log.size() ? grant_log[i] : 2'b00), 32'(exp_q[i]));
    chk("s3_cpu_served", 32'(cpu_done_cnt >= 2), 32'h1);
    chk("s3_dma_served", 32'(dma_ack_cnt >= 2), 32'h1);

    // DMA read timing out
    do_reset();
    clear_stats();
    forced_lat = 99;
    bus.iDmaAddr = 32'h80; bus.iDmaRead = 1'b1;
    run(20, 1'b1, 1'b1);
    chk("s4_read_cycles", 32'(rd_cycles),    32'd4);
    chk("s4_err_cnt",     32'(err_cnt),      32'd1);
    chk("s4_err_with_ack",32'(err_with_ack), 32'd1);
    chk("s4_dma_acks",    32'(dma_ack_cnt),  32'd1);
    chk("s4_dma_rdata",   dma_rdata,         ERR);
    @(negedge iClk);
    chk("s4_grant_after", 32'(bus.oGrant), 32'h0);
    step();

    // Ack arrives in the last allowed cycle: completes normally
    clear_stats();
    forced_lat = 3; fixed_data = 32'hCAFEF00D;
    bus.iDmaRead = 1'b1;
    run(20, 1'b1, 1'b1);
    chk("s4b_read_cycles", 32'(rd_cycles),   32'd4);
    chk("s4b_err_cnt",     32'(err_cnt),     32'd0);
    chk("s4b_dma_acks",    32'(dma_ack_cnt), 32'd1);
    chk("s4b_dma_rdata",   dma_rdata,        32'hCAFEF00D);

    // Read+Write together: write wins; then reset in the would-be timeout cycle
    do_reset();
    clear_stats();
    forced_lat = 99;
    bus.iCpuAddr = 32'h20; bus.iCpuWData = 32'h0BADF00D;
    bus.iCpuRead = 1'b1; bus.iCpuWrite = 1'b1;
    run(4, 1'b1, 1'b0);
    chk("s5_wr_cycles", 32'(wr_cycles), 32'd3);
    chk("s5_rd_cycles", 32'(rd_cycles), 32'd0);
    iRst = 1'b1;
    @(negedge iClk);
    chk("s5_rst_rdy", 32'(bus.oCpuRdy), 32'h0);
    chk("s5_rst_err", 32'(bus.oBusErr), 32'h0);
    step();
    iRst = 1'b0;
    clear_reqs();
    @(negedge iClk);
    chk("s5_post_grant", 32'(bus.oGrant),    32'h0);
    chk("s5_post_wr",    32'(bus.oMemWrite), 32'h0);
    chk("s5_post_rd",    32'(bus.oMemRead),  32'h0);
    chk("s5_post_ack",   32'(bus.oDmaAck),   32'h0);
    step();

    // Idle CPU: ready every cycle, bus quiet
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      chk("s6_rdy",   32'(bus.oCpuRdy),                  32'h1);
      chk("s6_strobe",32'(bus.oMemRead | bus.oMemWrite), 32'h0);
      step();
    end

    // Random traffic against the model
    forced_lat = -1; fixed_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.iCpuAddr  = $urandom(); bus.iCpuWData = $urandom();
      bus.iDmaAddr  = $urandom(); bus.iDmaWData = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        rb = 4'($urandom());
        bus.iCpuRead = rb[0]; bus.iCpuWrite = rb[1] & rb[2];
      end
      if ($urandom_range(0, 3) == 0) begin
        rb = 4'($urandom());
        bus.iDmaRead = rb[0]; bus.iDmaWrite = rb[1] & rb[3];
      end
      iRst = ($urandom_range(0, 299) == 0);
      step();
    end
    iRst = 1'b0;
    clear_reqs();
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
